// File: rtl/module_sipo_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// pkg_serial
// Shared types and helpers for the serial front-end blocks.
//   sipo_state_t : deserializer FSM state encoding (IDLE, SHIFT)
//   cnt_width()  : width of a counter able to represent 0..ancho
// -----------------------------------------------------------------------------
package pkg_serial;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  function automatic int cnt_width(input int ancho);
    return $clog2(ancho + 1);
  endfunction

endpackage : pkg_serial

// File: rtl/module_sipo_deserializer_bit_counter.sv
// -----------------------------------------------------------------------------
// module_bit_counter
// Up-counter running 0..MAX-1 with wrap, synchronous active-low reset,
// synchronous clear (priority over enable) and a terminal-count flag.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous reset, active low
//   clr_i    : synchronous clear to zero
//   en_i     : count enable; at terminal count the next enable wraps to 0
//   count_o  : registered count value
//   tc_o     : high while count_o == MAX-1 (decoded from the register only)
// -----------------------------------------------------------------------------
module module_bit_counter
  import pkg_serial::*;
#(
  parameter int MAX   = 8,
  parameter int WIDTH = cnt_width(MAX)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc;

  assign tc = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc;

endmodule : module_bit_counter

// File: rtl/module_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// module_sipo_deserializer
// Collects a serial bit stream into ANCHO-bit words and presents each finished
// word on data_out together with a one-cycle we strobe, ready to feed a
// parallel holding register directly.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low; zeroes all outputs
//   bit_in     : serial data bit
//   bit_valid  : bit_in is accepted on every edge where this is high
//   clear      : soft abort of the word in progress (beats bit_valid)
//   data_out   : last completed word, held between completions
//   we         : one-cycle strobe, data_out carries a new word
//   busy       : a word is partially received
//   bit_count  : bits currently held in the shift register (0..ANCHO-1)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no bits held; next accepted bit starts a word
// SHIFT | 1..ANCHO-1 bits held; the ANCHO-th bit completes and exits
// -----------------------------------------------------------------------------
module module_sipo_deserializer
  import pkg_serial::*;
#(
  parameter int ANCHO     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  input  logic                        clear,
  output logic [ANCHO-1:0]            data_out,
  output logic                        we,
  output logic                        busy,
  output logic [cnt_width(ANCHO)-1:0] bit_count
);

  localparam int CW = cnt_width(ANCHO);

  sipo_state_t      state_q, state_d;
  logic [ANCHO-1:0] sr_q, sr_d;
  logic [ANCHO-1:0] data_q, data_d;
  logic             we_q, we_d;
  logic [ANCHO-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;

  assign accept = bit_valid & ~clear;

  // The register is zero whenever a word starts, so the same shift also
  // serves as the "load first bit" operation in IDLE.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = (sr_q << 1) | ANCHO'(bit_in);
    end else begin : g_lsb_first
      assign shifted = (sr_q >> 1) | {bit_in, {(ANCHO-1){1'b0}}};
    end
  endgenerate

  // The counter sees the raw clear and bit_valid; its own clear priority
  // matches the FSM's, so both stay in step.
  module_bit_counter #(
    .MAX   (ANCHO),
    .WIDTH (CW)
  ) u_bit_counter (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (clear),
    .en_i    (bit_valid),
    .count_o (cnt),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    data_d  = data_q;
    we_d    = 1'b0;

    if (clear) begin
      state_d = IDLE;
      sr_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sr_d    = shifted;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            if (tc) begin
              data_d  = shifted;
              we_d    = 1'b1;
              sr_d    = '0;
              state_d = IDLE;
            end else begin
              sr_d = shifted;
            end
          end
        end
        default: begin
          state_d = IDLE;
          sr_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  assign data_out  = data_q;
  assign we        = we_q;
  assign busy      = (state_q == SHIFT);
  assign bit_count = cnt;

endmodule : module_sipo_deserializer

// File: tb/tb_module_sipo_deserializer.sv
module tb_module_sipo_deserializer;

  localparam int ANCHO = 8;
  localparam int CW    = $clog2(ANCHO + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic clear = 1'b0;

  logic [ANCHO-1:0] dout_m, dout_l;
  logic             we_m, we_l, busy_m, busy_l;
  logic [CW-1:0]    cnt_m, cnt_l;

  module_sipo_deserializer #(.ANCHO(ANCHO), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .data_out(dout_m), .we(we_m), .busy(busy_m), .bit_count(cnt_m)
  );

  module_sipo_deserializer #(.ANCHO(ANCHO), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .data_out(dout_l), .we(we_l), .busy(busy_l), .bit_count(cnt_l)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word is just a count of received bits plus an
  // arithmetic accumulator per bit order.
  int         m_cnt = 0;
  int         m_acc_m = 0;
  int         m_acc_l = 0;
  logic [7:0] e_dout_m = '0;
  logic [7:0] e_dout_l = '0;
  logic       e_we = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_cnt = 0; m_acc_m = 0; m_acc_l = 0;
      e_dout_m = '0; e_dout_l = '0; e_we = 1'b0;
    end else if (clear) begin
      m_cnt = 0; m_acc_m = 0; m_acc_l = 0; e_we = 1'b0;
    end else if (bit_valid) begin
      m_acc_m = (m_acc_m * 2 + int'(bit_in)) % 256;
      m_acc_l = m_acc_l + int'(bit_in) * (2 ** m_cnt);
      m_cnt   = m_cnt + 1;
      if (m_cnt == ANCHO) begin
        e_dout_m = 8'(m_acc_m);
        e_dout_l = 8'(m_acc_l);
        e_we     = 1'b1;
        m_cnt = 0; m_acc_m = 0; m_acc_l = 0;
      end else begin
        e_we = 1'b0;
      end
    end else begin
      e_we = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_data_out", 32'(dout_m), 32'(e_dout_m));
    chk("m_we",       32'(we_m),   32'(e_we));
    chk("m_busy",     32'(busy_m), 32'(m_cnt != 0));
    chk("m_count",    32'(cnt_m),  32'(m_cnt));
    chk("l_data_out", 32'(dout_l), 32'(e_dout_l));
    chk("l_we",       32'(we_l),   32'(e_we));
    chk("l_busy",     32'(busy_l), 32'(m_cnt != 0));
    chk("l_count",    32'(cnt_l),  32'(m_cnt));
  end

  task automatic step(input logic b, input logic v, input logic c);
    @(negedge clk);
    bit_in = b; bit_valid = v; clear = c;
  endtask

  // Sends w MSB first; with gap>0, inserts gap idle cycles after bits 2 and 5.
  task automatic send_word(input logic [7:0] w, input int gap,
                           input logic [7:0] exp_m, input logic [7:0] exp_l,
                           input string tag);
    logic [7:0] wv;
    wv = w;
    for (int i = 0; i < 8; i++) begin
      step(wv[7-i], 1'b1, 1'b0);
      if (i == 0) begin
        @(posedge clk); #1;
        chk({tag, "_busy_first"}, 32'(busy_m), 32'd1);
      end
      if (gap > 0 && (i == 1 || i == 4)) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_gap_count"}, 32'(cnt_m), (i == 1) ? 32'd2 : 32'd5);
      end
    end
    @(posedge clk); #1;
    chk({tag, "_m_word"}, 32'(dout_m), 32'(exp_m));
    chk({tag, "_m_we"},   32'(we_m),   32'd1);
    chk({tag, "_l_word"}, 32'(dout_l), 32'(exp_l));
    chk({tag, "_l_we"},   32'(we_l),   32'd1);
    step(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_we_drop"}, 32'(we_m), 32'd0);
  endtask

  initial begin
    int         npulse;
    int         pidx[2];
    logic [7:0] pdat[2];
    logic [15:0] stream;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(dout_m), 32'd0);
    chk("rst_outputs",  32'({we_m, busy_m, cnt_m}), 32'd0);
    @(negedge clk) rst = 1'b1;

    // MSB-first 0x1E / LSB-first 0x78 from the same bit sequence
    send_word(8'h1E, 0, 8'h1E, 8'h78, "plain");

    // Gapped input
    send_word(8'h1E, 3, 8'h1E, 8'h78, "gapped");

    // Back-to-back A5 then 3C (both bit-palindromes, so both DUTs agree)
    stream = 16'hA53C;
    npulse = 0;
    pidx[0] = 0; pidx[1] = 0; pdat[0] = '0; pdat[1] = '0;
    for (int i = 0; i < 16; i++) begin
      step(stream[15-i], 1'b1, 1'b0);
      @(posedge clk); #1;
      if (we_m) begin
        if (npulse < 2) begin
          pidx[npulse] = i;
          pdat[npulse] = dout_m;
        end
        npulse++;
      end
    end
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_pulses", 32'(npulse), 32'd2);
    chk("b2b_first_at", 32'(pidx[0]), 32'd7);
    chk("b2b_spacing", 32'(pidx[1] - pidx[0]), 32'd8);
    chk("b2b_word0", 32'(pdat[0]), 32'hA5);
    chk("b2b_word1", 32'(pdat[1]), 32'h3C);

    // Clear after 5 bits
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("clr_mid_we",   32'(we_m),   32'd0);
    chk("clr_mid_hold", 32'(dout_m), 32'h3C);
    chk("clr_mid_cnt",  32'(cnt_m),  32'd0);
    step(1'b0, 1'b0, 1'b0);
    send_word(8'hC3, 0, 8'hC3, 8'hC3, "after_clr");

    // Clear on the same edge as the 8th bit
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("clr_last_we",   32'(we_m),   32'd0);
    chk("clr_last_hold", 32'(dout_m), 32'hC3);
    chk("clr_last_cnt",  32'(cnt_m),  32'd0);
    step(1'b0, 1'b0, 1'b0);

    // Reset after 4 bits
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_data", 32'(dout_m), 32'd0);
    chk("rst_mid_outs", 32'({we_m, busy_m, cnt_m}), 32'd0);
    @(negedge clk) rst = 1'b1;
    send_word(8'h1E, 0, 8'h1E, 8'h78, "after_rst");

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_module_sipo_deserializer
